// File: rtl/rcui2c_ctrl.sv
// -----------------------------------------------------------------------------
// rcui2c_ctrl
// Sequencer for the board controller's RCU I2C slave port.
//
// The asynchronous RCU bus lines are synchronised and glitch filtered. START
// and STOP are detected on the filtered levels. The block then decodes the
// card address, the register address and 16-bit write data, and drives the
// one-hot I2C state vector that the slave TX/RX datapath shares. It issues
// register-file read/write strobes and drives ACKs and read data onto SDA.
//
// Ports
//   clk          board clock; the only clock of the block
//   reset        asynchronous, active-low reset
//   card_addr    geographic card address (5 bits)
//   rcu_scl      I2C clock from the RCU (asynchronous)
//   rcu_sda_in   I2C data from the RCU (asynchronous)
//   rcu_sda_out  open-drain data drive, 1 = released
//   state        one-hot I2C state (9 bits) to the datapath
//   reg_addr     latched register address
//   reg_wr_data  received write data {byte1, byte2}
//   reg_wr       1-clk write strobe
//   reg_rd       1-clk read strobe
//   reg_rd_data  read data, valid RD_LAT clks after reg_rd
// -----------------------------------------------------------------------------
module rcui2c_ctrl #(
  parameter int FILT_LEN = 3,
  parameter int RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  card_addr,
  input  logic        rcu_scl,
  input  logic        rcu_sda_in,
  output logic        rcu_sda_out,
  output logic [8:0]  state,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wr_data,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rd_data
);

  typedef enum logic [8:0] {
    st_idle          = 9'h001,
    st_card_addr_rx  = 9'h002,
    st_slave_ack     = 9'h004,
    st_reg_addr_rx   = 9'h008,
    st_rx_data       = 9'h010,
    st_tx_data       = 9'h020,
    st_master_ack    = 9'h040,
    st_master_no_ack = 9'h080,
    st_stop          = 9'h100
  } i2c_state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: lane 0 = scl, lane 1 = sda. Both lanes take the same
  // path, so their relative timing is preserved after filtering.
  // ---------------------------------------------------------------------------
  logic [1:0] bus_raw;
  logic [1:0] bus_filt;
  logic [1:0] bus_filt_d;

  assign bus_raw = {rcu_sda_in, rcu_scl};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cond
      logic                sync1_reg;
      logic                sync2_reg;
      logic [FILT_LEN-1:0] hist_reg;
      logic                filt_reg;
      logic                filt_d_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg  <= 1'b1;
          sync2_reg  <= 1'b1;
          hist_reg   <= '1;
          filt_reg   <= 1'b1;
          filt_d_reg <= 1'b1;
        end else begin
          sync1_reg <= bus_raw[gi];
          sync2_reg <= sync1_reg;
          hist_reg  <= {hist_reg[FILT_LEN-2:0], sync2_reg};
          // A new level is only accepted once every recent sample agrees.
          if (&hist_reg) begin
            filt_reg <= 1'b1;
          end else if (~|hist_reg) begin
            filt_reg <= 1'b0;
          end
          filt_d_reg <= filt_reg;
        end
      end

      assign bus_filt[gi]   = filt_reg;
      assign bus_filt_d[gi] = filt_d_reg;
    end
  endgenerate

  logic scl_rise, scl_fall, sda_bit;
  logic start_det, stop_det;

  assign scl_rise  =  bus_filt[0] & ~bus_filt_d[0];
  assign scl_fall  = ~bus_filt[0] &  bus_filt_d[0];
  assign sda_bit   =  bus_filt[1];
  assign start_det = ~bus_filt[1] &  bus_filt_d[1] & bus_filt[0];
  assign stop_det  =  bus_filt[1] & ~bus_filt_d[1] & bus_filt[0];

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  i2c_state_t         state_reg,    state_next;
  logic [3:0]         bitcnt_reg,   bitcnt_next;
  logic [7:0]         shift_reg,    shift_next;
  logic [2:0]         ack_cnt_reg,  ack_cnt_next;
  logic               rw_reg,       rw_next;
  logic [7:0]         reg_addr_reg, reg_addr_next;
  logic [15:0]        wr_data_reg,  wr_data_next;
  logic [15:0]        tx_shift_reg, tx_shift_next;
  logic               sda_out_reg,  sda_out_next;
  logic               reg_wr_reg,   reg_wr_next;
  logic               reg_rd_reg,   reg_rd_next;
  logic [RD_LAT-1:0]  rd_pipe_reg;
  logic [7:0]         rx_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= st_idle;
      bitcnt_reg   <= '0;
      shift_reg    <= '0;
      ack_cnt_reg  <= '0;
      rw_reg       <= 1'b0;
      reg_addr_reg <= '0;
      wr_data_reg  <= '0;
      tx_shift_reg <= '0;
      sda_out_reg  <= 1'b1;
      reg_wr_reg   <= 1'b0;
      reg_rd_reg   <= 1'b0;
      rd_pipe_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      bitcnt_reg   <= bitcnt_next;
      shift_reg    <= shift_next;
      ack_cnt_reg  <= ack_cnt_next;
      rw_reg       <= rw_next;
      reg_addr_reg <= reg_addr_next;
      wr_data_reg  <= wr_data_next;
      tx_shift_reg <= tx_shift_next;
      sda_out_reg  <= sda_out_next;
      reg_wr_reg   <= reg_wr_next;
      reg_rd_reg   <= reg_rd_next;
      // Delay line marking the cycle in which reg_rd_data becomes valid.
      rd_pipe_reg  <= (rd_pipe_reg << 1) | RD_LAT'(reg_rd_reg);
    end
  end

  always_comb begin
    state_next    = state_reg;
    bitcnt_next   = bitcnt_reg;
    shift_next    = shift_reg;
    ack_cnt_next  = ack_cnt_reg;
    rw_next       = rw_reg;
    reg_addr_next = reg_addr_reg;
    wr_data_next  = wr_data_reg;
    tx_shift_next = tx_shift_reg;
    sda_out_next  = sda_out_reg;
    reg_wr_next   = 1'b0;
    reg_rd_next   = 1'b0;
    rx_byte       = {shift_reg[6:0], sda_bit};

    if (rd_pipe_reg[RD_LAT-1]) begin
      tx_shift_next = reg_rd_data;
    end

    // Bus conditions take priority over any scl edge in the same clk.
    if (stop_det) begin
      state_next   = st_idle;
      sda_out_next = 1'b1;
    end else if (start_det) begin
      state_next   = st_card_addr_rx;
      bitcnt_next  = '0;
      ack_cnt_next = '0;
      sda_out_next = 1'b1;
    end else begin
      case (state_reg)
        st_card_addr_rx: begin
          if (scl_rise) begin
            shift_next  = rx_byte;
            bitcnt_next = bitcnt_reg + 4'd1;
          end else if (scl_fall && bitcnt_reg == 4'd8) begin
            if (shift_reg[7:6] == 2'b00 && shift_reg[5:1] == card_addr) begin
              state_next   = st_slave_ack;
              rw_next      = shift_reg[0];
              sda_out_next = 1'b0;
            end else begin
              state_next   = st_idle;
              sda_out_next = 1'b1;
            end
          end
        end

        st_slave_ack: begin
          // ack_cnt_reg counts the ACKs already completed in this transfer.
          if (scl_fall) begin
            bitcnt_next  = '0;
            ack_cnt_next = ack_cnt_reg + 3'd1;
            sda_out_next = 1'b1;
            case (ack_cnt_reg)
              3'd0: state_next = st_reg_addr_rx;
              3'd1: begin
                if (rw_reg) begin
                  // First read bit goes out on the same fall that ends the ACK.
                  state_next    = st_tx_data;
                  sda_out_next  = tx_shift_reg[15];
                  tx_shift_next = {tx_shift_reg[14:0], 1'b0};
                end else begin
                  state_next = st_rx_data;
                end
              end
              3'd2: state_next = st_rx_data;
              default: begin
                state_next  = st_stop;
                reg_wr_next = 1'b1;
              end
            endcase
          end
        end

        st_reg_addr_rx: begin
          if (scl_rise) begin
            shift_next  = rx_byte;
            bitcnt_next = bitcnt_reg + 4'd1;
            if (bitcnt_reg == 4'd7) begin
              reg_addr_next = rx_byte;
              reg_rd_next   = rw_reg;
            end
          end else if (scl_fall && bitcnt_reg == 4'd8) begin
            state_next   = st_slave_ack;
            sda_out_next = 1'b0;
          end
        end

        st_rx_data: begin
          if (scl_rise) begin
            shift_next  = rx_byte;
            bitcnt_next = bitcnt_reg + 4'd1;
            if (bitcnt_reg == 4'd7) begin
              if (ack_cnt_reg == 3'd2) begin
                wr_data_next[15:8] = rx_byte;
              end else begin
                wr_data_next[7:0] = rx_byte;
              end
            end
          end else if (scl_fall && bitcnt_reg == 4'd8) begin
            state_next   = st_slave_ack;
            sda_out_next = 1'b0;
          end
        end

        st_tx_data: begin
          if (scl_rise) begin
            bitcnt_next = bitcnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt_reg == 4'd8) begin
              state_next   = st_master_ack;
              bitcnt_next  = '0;
              sda_out_next = 1'b1;
            end else begin
              sda_out_next  = tx_shift_reg[15];
              tx_shift_next = {tx_shift_reg[14:0], 1'b0};
            end
          end
        end

        st_master_ack: begin
          // Entering tx_data on the rise lets the next fall drive the MSB.
          if (scl_rise) begin
            bitcnt_next = '0;
            if (ack_cnt_reg == 3'd2 && !sda_bit) begin
              state_next   = st_tx_data;
              ack_cnt_next = 3'd3;
            end else begin
              state_next = st_master_no_ack;
            end
          end
        end

        st_idle, st_master_no_ack, st_stop: begin
          state_next = state_reg;
        end

        default: begin
          state_next   = st_idle;
          sda_out_next = 1'b1;
        end
      endcase
    end
  end

  assign state       = state_reg;
  assign rcu_sda_out = sda_out_reg;
  assign reg_addr    = reg_addr_reg;
  assign reg_wr_data = wr_data_reg;
  assign reg_wr      = reg_wr_reg;
  assign reg_rd      = reg_rd_reg;

endmodule

// File: tb/tb_rcui2c_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rcui2c_ctrl
// Bench for rcui2c_ctrl. A bus-level master drives wired-AND SCL/SDA. A small
// register-file model answers reads after RD_LAT clks. Expected ACKs, read
// bytes, strobes and states come from transaction-level rules.
// -----------------------------------------------------------------------------
module tb_rcui2c_ctrl;

  localparam int FILT_LEN = 3;
  localparam int RD_LAT   = 2;
  localparam int Q        = 10;  // clks per quarter SCL period

  localparam logic [8:0] ST_IDLE  = 9'h001;
  localparam logic [8:0] ST_CADDR = 9'h002;
  localparam logic [8:0] ST_SACK  = 9'h004;
  localparam logic [8:0] ST_TX    = 9'h020;
  localparam logic [8:0] ST_MACK  = 9'h040;
  localparam logic [8:0] ST_NOACK = 9'h080;
  localparam logic [8:0] ST_STOP  = 9'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  card_v = 5'h0A;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        rcu_sda_out;
  logic [8:0]  state;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rd_data = 16'h0000;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          rd_age = 1000;
  logic [7:0]  wr_addr_seen, rd_addr_seen;
  logic [15:0] wr_data_seen;
  logic [15:0] rd_val = 16'h0000;

  always #5 clk = ~clk;

  rcui2c_ctrl #(.FILT_LEN(FILT_LEN), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .card_addr   (card_v),
    .rcu_scl     (scl_m),
    .rcu_sda_in  (sda_m & rcu_sda_out),
    .rcu_sda_out (rcu_sda_out),
    .state       (state),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_rd_data (reg_rd_data)
  );

  // Strobe monitor and register-file read model: data is junk until exactly
  // RD_LAT clks after the reg_rd cycle, then holds the read value.
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cnt++;
      wr_addr_seen = reg_addr;
      wr_data_seen = reg_wr_data;
    end
    if (reg_rd) begin
      rd_cnt++;
      rd_addr_seen = reg_addr;
      rd_age = 0;
      reg_rd_data = ~rd_val;
    end else if (rd_age < 1000) begin
      rd_age++;
      if (rd_age == RD_LAT) reg_rd_data = rd_val;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit hdr_match(input logic [7:0] hdr, input logic [4:0] card);
    return hdr[7:1] == {2'b00, card};
  endfunction

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    sda_m = 1'b1; wait_q(2);
  endtask

  // glitch_bit selects a bit whose high phase carries a 1-clk scl low pulse
  // together with a 1-clk sda flip (-1 = none).
  task automatic send_byte(input logic [7:0] b, input int glitch_bit,
                           output logic ack, output logic [8:0] st_ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q(1);
      scl_m = 1'b1; wait_q(1);
      if (i == glitch_bit) begin
        scl_m = 1'b0; sda_m = ~b[i];
        @(negedge clk);
        scl_m = 1'b1; sda_m = b[i];
        repeat (Q - 1) @(negedge clk);
      end else begin
        wait_q(1);
      end
      scl_m = 1'b0; wait_q(1);
    end
    sda_m = 1'b1; wait_q(1);
    st_ack = state;
    scl_m = 1'b1; wait_q(1);
    ack = rcu_sda_out;
    wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b, output logic [8:0] st_bit,
                           output logic [8:0] st_pre, output logic [8:0] st_post);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_q(1);
      scl_m = 1'b1; wait_q(1);
      b[i] = rcu_sda_out;
      if (i == 3) st_bit = state;
      wait_q(1);
      scl_m = 1'b0; wait_q(1);
    end
    sda_m = mack; wait_q(1);
    st_pre = state;
    scl_m = 1'b1; wait_q(2);
    st_post = state;
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic run_write(input logic [7:0] hdr, input logic [7:0] ra, input logic [15:0] wd,
                           input int n_data, input int glitch_bit);
    logic ack;
    logic [8:0] st;
    bit m, full;
    m = hdr_match(hdr, card_v);
    full = m && (n_data == 2);
    wr_cnt = 0; rd_cnt = 0;
    bus_start();
    send_byte(hdr, glitch_bit, ack, st);
    check_val("wr_hdr_ack", ack, m ? 0 : 1);
    check_val("wr_hdr_state", st, m ? ST_SACK : ST_IDLE);
    send_byte(ra, -1, ack, st);
    check_val("wr_ra_ack", ack, m ? 0 : 1);
    for (int i = 0; i < n_data; i++) begin
      send_byte(i == 0 ? wd[15:8] : wd[7:0], -1, ack, st);
      check_val("wr_data_ack", ack, m ? 0 : 1);
    end
    if (n_data == 2) check_val("wr_state_pre_stop", state, m ? ST_STOP : ST_IDLE);
    bus_stop();
    check_val("wr_state_idle", state, ST_IDLE);
    check_val("wr_strobe_cnt", wr_cnt, full ? 1 : 0);
    check_val("wr_no_rd", rd_cnt, 0);
    if (full) begin
      check_val("wr_reg_addr", wr_addr_seen, ra);
      check_val("wr_reg_data", wr_data_seen, wd);
    end
    $display("write card=%h hdr=%h ra=%h data=%h bytes=%0d glitch=%0d match=%0d wr_pulses=%0d",
             card_v, hdr, ra, wd, n_data, glitch_bit, m, wr_cnt);
  endtask

  task automatic run_read(input bit do_start, input logic [7:0] hdr, input logic [7:0] ra,
                          input logic [15:0] val, input logic first_nack);
    logic ack;
    logic [7:0] b;
    logic [8:0] st, s_bit, s_pre, s_post;
    bit m;
    m = hdr_match(hdr, card_v);
    rd_val = val;
    wr_cnt = 0; rd_cnt = 0;
    if (do_start) bus_start();
    send_byte(hdr, -1, ack, st);
    check_val("rd_hdr_ack", ack, m ? 0 : 1);
    send_byte(ra, -1, ack, st);
    check_val("rd_ra_ack", ack, m ? 0 : 1);
    check_val("rd_strobe_cnt", rd_cnt, m ? 1 : 0);
    if (m) check_val("rd_reg_addr", rd_addr_seen, ra);
    recv_byte(first_nack, b, s_bit, s_pre, s_post);
    check_val("rd_byte_hi", b, m ? val[15:8] : 8'hFF);
    check_val("rd_st_tx1", s_bit, m ? ST_TX : ST_IDLE);
    check_val("rd_st_mack1", s_pre, m ? ST_MACK : ST_IDLE);
    check_val("rd_st_after1", s_post, !m ? ST_IDLE : (first_nack ? ST_NOACK : ST_TX));
    if (!first_nack) begin
      recv_byte(1'b1, b, s_bit, s_pre, s_post);
      check_val("rd_byte_lo", b, m ? val[7:0] : 8'hFF);
      check_val("rd_st_tx2", s_bit, m ? ST_TX : ST_IDLE);
      check_val("rd_st_mack2", s_pre, m ? ST_MACK : ST_IDLE);
      check_val("rd_st_after2", s_post, m ? ST_NOACK : ST_IDLE);
    end
    bus_stop();
    check_val("rd_state_idle", state, ST_IDLE);
    check_val("rd_no_wr", wr_cnt, 0);
    check_val("rd_strobe_total", rd_cnt, m ? 1 : 0);
    $display("read  card=%h hdr=%h ra=%h value=%h first_nack=%0d match=%0d rd_pulses=%0d",
             card_v, hdr, ra, val, first_nack, m, rd_cnt);
  endtask

  initial begin
    logic ack;
    logic [8:0] st;
    logic [7:0] hdr, ra;
    logic [15:0] val;
    int kind;

    repeat (4) @(negedge clk);
    check_val("rst_state", state, ST_IDLE);
    check_val("rst_sda", rcu_sda_out, 1);
    check_val("rst_wr", reg_wr, 0);
    check_val("rst_rd", reg_rd, 0);
    check_val("rst_reg_addr", reg_addr, 0);
    check_val("rst_wr_data", reg_wr_data, 0);
    reset = 1'b1;
    wait_q(2);
    check_val("rst_idle_after", state, ST_IDLE);

    // Directed transfers
    card_v = 5'h0A;
    run_write(8'h14, 8'h3C, 16'hBEEF, 2, -1);
    run_read(1'b1, 8'h15, 8'h21, 16'hA55A, 1'b0);
    run_write(8'h16, 8'h3C, 16'h1234, 2, -1);
    run_write(8'h14, 8'h3C, 16'hC0DE, 1, -1);
    run_write(8'h14, 8'h55, 16'h0F0F, 2, 3);

    // Repeated START while the slave is sending data (MSB 1 keeps sda free).
    rd_val = 16'hC3C3;
    wr_cnt = 0; rd_cnt = 0;
    bus_start();
    send_byte(8'h15, -1, ack, st);
    send_byte(8'h10, -1, ack, st);
    check_val("rs_pre_state", state, ST_TX);
    bus_start();
    check_val("rs_state", state, ST_CADDR);
    check_val("rs_sda", rcu_sda_out, 1);
    $display("restart during tx_data state=%h", state);
    run_read(1'b0, 8'h15, 8'h42, 16'h9157, 1'b0);

    // Reset pulse in the middle of a read while the slave drives sda low.
    rd_val = 16'h5A3C;
    bus_start();
    send_byte(8'h15, -1, ack, st);
    send_byte(8'h77, -1, ack, st);
    wait_q(1);
    check_val("mid_rst_pre_sda", rcu_sda_out, 0);
    reset = 1'b0;
    #1;
    check_val("mid_rst_sda", rcu_sda_out, 1);
    check_val("mid_rst_state", state, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    scl_m = 1'b1; sda_m = 1'b1;
    wait_q(2);
    check_val("mid_rst_idle", state, ST_IDLE);
    $display("reset mid-read state=%h sda=%b", state, rcu_sda_out);

    // Randomised transfers
    for (int t = 0; t < 8; t++) begin
      card_v = 5'($urandom);
      kind = int'($urandom_range(0, 3));
      ra = 8'($urandom);
      val = 16'($urandom);
      case (kind)
        0: run_write({2'b00, card_v, 1'b0}, ra, val, 2, -1);
        1: run_read(1'b1, {2'b00, card_v, 1'b1}, ra, val, 1'($urandom_range(0, 1)));
        2: begin
          hdr = 8'($urandom);
          if (hdr[0]) run_read(1'b1, hdr, ra, val, 1'b0);
          else        run_write(hdr, ra, val, 2, -1);
        end
        default: run_write({2'b00, card_v, 1'b0}, ra, val, 1, -1);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
